receiver: RTL and testbench

//   Deserialises the one-bit-per-clock serial frame produced by the team's serial transmitter.

---
 rtl/receiver_pkg.sv | 20 ++
 rtl/rx_holding_reg.sv | 46 ++++
 rtl/receiver.sv | 87 ++++++++
 tb/tb_receiver.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/receiver_pkg.sv
// Shared serial-link definitions: payload width, state encodings and the
// even-parity helper also used by the transmitter.
package receiver_pkg;

  localparam int DATA_BITS = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DATA  = 3'd1,
    ST_PAR   = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  // Parity bit that makes the total number of ones (data + parity) even.
  function automatic logic parity_even(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/rx_holding_reg.sv
// Output holding register: keeps one received word and its error flags,
// and hands it to the consumer over a valid/ready port.
module rx_holding_reg
  import receiver_pkg::*;
#(
  parameter int DATA_BITS = receiver_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] load_data,
  input  logic                 load_perr,
  input  logic                 load_ferr,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  // Handshake: a word transfers on any edge where valid && ready. Once valid
  // is raised, data_out and the flags hold until that transfer or until a
  // newly completed word replaces them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (load) begin
      data_out   <= load_data;
      valid      <= 1'b1;
      parity_err <= load_perr;
      frame_err  <= load_ferr;
      overrun    <= valid && !ready;
    end else if (valid && ready) begin
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule

// File: rtl/receiver.sv
// Serial frame receiver: start(0), DATA_BITS data LSB first, even parity,
// stop(1). One sample per clock; completed words go to rx_holding_reg.
module receiver
  import receiver_pkg::*;
#(
  parameter int DATA_BITS = receiver_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [2:0]           state_dbg
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  rx_state_t            state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_bit;
  logic                 word_done;
  logic                 word_perr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!serial_in) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          shift_reg <= {serial_in, shift_reg[DATA_BITS-1:1]};
          bit_cnt   <= bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_BIT) state <= ST_PAR;
        end
        ST_PAR: begin
          parity_bit <= serial_in;
          state      <= ST_STOP;
        end
        ST_STOP: begin
          state <= serial_in ? ST_IDLE : ST_BREAK;
        end
        // A held-low line must return high before another start is honoured.
        ST_BREAK: begin
          if (serial_in) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The word is loaded on the same edge that samples the stop bit.
  assign word_done = (state == ST_STOP);
  assign word_perr = parity_even(shift_reg) ^ parity_bit;
  assign state_dbg = state;

  rx_holding_reg #(
    .DATA_BITS(DATA_BITS)
  ) u_hold (
    .clk       (clk),
    .rstn      (rstn),
    .load      (word_done),
    .load_data (shift_reg),
    .load_perr (word_perr),
    .load_ferr (!serial_in),
    .ready     (ready),
    .data_out  (data_out),
    .valid     (valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver: frames driven bit by bit, delivered words
// checked against an expected queue of {overrun, frame_err, parity_err, data}.
module tb_receiver;

  logic       clk;
  logic       rstn;
  logic       serial_in;
  logic [6:0] data_out;
  logic       valid;
  logic       ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic [2:0] state_dbg;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int prev_deliv = 0;
  int last_deliv = 0;
  logic [9:0] exp_q[$];

  receiver dut (
    .clk       (clk),
    .rstn      (rstn),
    .serial_in (serial_in),
    .data_out  (data_out),
    .valid     (valid),
    .ready     (ready),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .state_dbg (state_dbg)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected entry: {overrun, frame_err, parity_err, data}
  function automatic logic [9:0] mk_exp(input logic ovr, input logic ferr,
                                        input logic perr, input logic [6:0] d);
    return {ovr, ferr, perr, d};
  endfunction

  // Drive one frame, one bit per clock; returns at posedge+1 after the stop edge.
  task automatic send_frame(input logic [6:0] d, input logic bad_par,
                            input logic stop_bit, input logic chk_lat);
    logic [9:0] bits;
    bits = {stop_bit, (^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      serial_in = bits[i];
      @(posedge clk);
      #1;
      if (chk_lat && i == 8) check("lat_pre", {31'd0, valid}, 32'd0);
    end
    serial_in = 1'b1;
    if (chk_lat) check("lat_post", {31'd0, valid}, 32'd1);
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: a word is delivered in any cycle with valid && ready.
  always @(negedge clk) begin
    if (rstn && valid && ready) begin
      prev_deliv = last_deliv;
      last_deliv = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_word", {22'd0, overrun, frame_err, parity_err, data_out}, 32'h3ff);
      end else begin
        check("word", {22'd0, overrun, frame_err, parity_err, data_out},
              {22'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rstn = 1'b0;
    serial_in = 1'b1;
    ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", {25'd0, data_out}, 32'd0);
    check("rst_flags", {28'd0, valid, parity_err, frame_err, overrun}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, 32'd0);
    rstn = 1'b1;
    idle(2);

    // 1: single word, latency and flags
    exp_q.push_back(mk_exp(0, 0, 0, 7'h55));
    send_frame(7'h55, 1'b0, 1'b1, 1'b1);
    idle(3);
    check("t1_valid_drop", {31'd0, valid}, 32'd0);

    // 2: back-to-back words
    exp_q.push_back(mk_exp(0, 0, 0, 7'h01));
    exp_q.push_back(mk_exp(0, 0, 0, 7'h7F));
    exp_q.push_back(mk_exp(0, 0, 0, 7'h00));
    send_frame(7'h01, 1'b0, 1'b1, 1'b1);
    send_frame(7'h7F, 1'b0, 1'b1, 1'b1);
    send_frame(7'h00, 1'b0, 1'b1, 1'b1);
    idle(2);
    check("t2_spacing", last_deliv - prev_deliv, 32'd10);

    // 3: wrong parity bit
    exp_q.push_back(mk_exp(0, 0, 1, 7'h55));
    send_frame(7'h55, 1'b1, 1'b1, 1'b0);
    idle(2);

    // 4: stop bit low, line held low, then released
    exp_q.push_back(mk_exp(0, 1, 0, 7'h2A));
    send_frame(7'h2A, 1'b0, 1'b0, 1'b0);
    serial_in = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("t4_break_state", {29'd0, state_dbg}, 32'd4);
    check("t4_no_valid", {31'd0, valid}, 32'd0);
    idle(1);
    check("t4_idle_state", {29'd0, state_dbg}, 32'd0);
    exp_q.push_back(mk_exp(0, 0, 0, 7'h15));
    send_frame(7'h15, 1'b0, 1'b1, 1'b1);
    idle(2);

    // 5: consumer stalled, second word overwrites the first
    ready = 1'b0;
    send_frame(7'h11, 1'b0, 1'b1, 1'b0);
    check("t5_first_ovr", {31'd0, overrun}, 32'd0);
    send_frame(7'h22, 1'b0, 1'b1, 1'b0);
    check("t5_data", {25'd0, data_out}, 32'h22);
    check("t5_ovr", {31'd0, overrun}, 32'd1);
    idle(2);
    check("t5_held", {31'd0, valid}, 32'd1);
    exp_q.push_back(mk_exp(1, 0, 0, 7'h22));
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    check("t5_consumed", {31'd0, valid}, 32'd0);
    send_frame(7'h33, 1'b0, 1'b1, 1'b0);
    check("t5_new_data", {25'd0, data_out}, 32'h33);
    check("t5_new_ovr", {31'd0, overrun}, 32'd0);
    exp_q.push_back(mk_exp(0, 0, 0, 7'h33));
    ready = 1'b1;
    idle(2);

    // 6: reset in the middle of a frame
    begin
      logic [6:0] d;
      d = 7'h3C;
      serial_in = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        serial_in = d[i];
        @(posedge clk);
        #1;
      end
    end
    rstn = 1'b0;
    #2;
    check("t6_rst_state", {29'd0, state_dbg}, 32'd0);
    check("t6_rst_valid", {31'd0, valid}, 32'd0);
    serial_in = 1'b1;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(3);
    exp_q.push_back(mk_exp(0, 0, 0, 7'h0F));
    send_frame(7'h0F, 1'b0, 1'b1, 1'b1);
    idle(5);

    check("drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
